// File: rtl/bin_to_sseg_conv.sv
// Sequential binary-to-BCD (double-dabble, one shift per clock) with 7-segment encoding
// for a 4-digit multiplexed display. Outputs update only when a conversion completes.
module bin_to_sseg_conv #(
  parameter int unsigned W        = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  input  logic [3:0]   dp_in,
  output logic         ready,
  output logic         done_tick,
  output logic         ovf,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic [7:0]   seg3,
  output logic [7:0]   seg2,
  output logic [7:0]   seg1,
  output logic [7:0]   seg0
);

  localparam logic [13:0] MaxVal = 14'd9999;
  localparam logic [3:0]  NIter  = 4'd14;

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

  state_e           state_q, state_d;
  logic [13:0]      shift_q, shift_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       dp_q, dp_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             ready_q, ready_d;
  logic             done_tick_q, done_tick_d;
  logic             ovf_q, ovf_d;
  logic [3:0][3:0]  bcd_q, bcd_d;
  logic [3:0][7:0]  seg_q, seg_d;

  logic [13:0]      bin_ext;
  logic [15:0]      acc_adj;
  logic [3:0][3:0]  fin_digit;
  logic [3:0]       blank;
  logic [3:0][7:0]  fin_seg;

  assign bin_ext = 14'(bin);

  // Active-low g..a pattern for one decimal digit.
  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction on every digit, evaluated on the pre-shift accumulator.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] > 4'd4) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Final digit decode, blanking and dp insertion, consumed only in StDone.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fin_digit[i] = acc_q[4*i +: 4];
    end
    blank[0] = 1'b0;
    blank[3] = BLANK_LZ && (fin_digit[3] == 4'd0);
    blank[2] = blank[3] && (fin_digit[2] == 4'd0);
    blank[1] = blank[2] && (fin_digit[1] == 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (ovf_flag_q) begin
        fin_seg[i] = {~dp_q[i], 7'h3F};
      end else if (blank[i]) begin
        fin_seg[i] = {~dp_q[i], 7'h7F};
      end else begin
        fin_seg[i] = {~dp_q[i], enc_digit(fin_digit[i])};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    n_d         = n_q;
    dp_d        = dp_q;
    ovf_flag_d  = ovf_flag_q;
    done_tick_d = 1'b0;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    seg_d       = seg_q;

    unique case (state_q)
      StIdle: begin
        if (start && ready_q) begin
          shift_d    = bin_ext;
          dp_d       = dp_in;
          acc_d      = 16'h0000;
          n_d        = NIter;
          ovf_flag_d = (bin_ext > MaxVal);
          state_d    = StOp;
        end
      end
      StOp: begin
        acc_d   = {acc_adj[14:0], shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
        n_d     = n_q - 4'd1;
        if (n_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_tick_d = 1'b1;
        ovf_d       = ovf_flag_q;
        seg_d       = fin_seg;
        bcd_d       = ovf_flag_q ? '0 : fin_digit;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Ready reasserts one cycle after the done pulse, so a start during it is dropped.
    ready_d = (state_d == StIdle) && (state_q != StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      dp_q        <= '0;
      ovf_flag_q  <= 1'b0;
      ready_q     <= 1'b1;
      done_tick_q <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      seg_q       <= {4{8'hFF}};
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      dp_q        <= dp_d;
      ovf_flag_q  <= ovf_flag_d;
      ready_q     <= ready_d;
      done_tick_q <= done_tick_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      seg_q       <= seg_d;
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_tick_q;
  assign ovf       = ovf_q;
  assign bcd3      = bcd_q[3];
  assign bcd2      = bcd_q[2];
  assign bcd1      = bcd_q[1];
  assign bcd0      = bcd_q[0];
  assign seg3      = seg_q[3];
  assign seg2      = seg_q[2];
  assign seg1      = seg_q[1];
  assign seg0      = seg_q[0];

endmodule

// File: tb/tb_bin_to_sseg_conv.sv
// Scoreboard bench for bin_to_sseg_conv: stimulus pushes expected results, a monitor pops
// and compares on each done_tick, including the 15-cycle latency and ready handshake.
module tb_bin_to_sseg_conv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [3:0]  dp_in;
  logic        ready, done_tick, ovf;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic [7:0]  seg3, seg2, seg1, seg0;

  bin_to_sseg_conv #(.W(14), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .dp_in     (dp_in),
    .ready     (ready),
    .done_tick (done_tick),
    .ovf       (ovf),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .seg3      (seg3),
    .seg2      (seg2),
    .seg1      (seg1),
    .seg0      (seg0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [31:0] seg;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_count = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per done_tick.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_tick === 1'b1) begin
        done_count++;
        if (sb.size() == 0) begin
          chk("unexpected_done_tick", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("bcd", 64'({bcd3, bcd2, bcd1, bcd0}), 64'(e.bcd));
          chk("seg", 64'({seg3, seg2, seg1, seg0}), 64'(e.seg));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("ready_low_at_done", 64'(ready), 64'd0);
          @(posedge clk);
          #1;
          chk("done_tick_one_cycle", 64'(done_tick), 64'd0);
          chk("ready_after_done", 64'(ready), 64'd1);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Issue one start pulse; accepting edge is the next posedge, done visible 15 edges later.
  task automatic issue(input logic [13:0] b, input logic [3:0] dp,
                       input logic [15:0] ebcd, input logic [31:0] eseg, input logic eovf);
    exp_t e;
    wait_ready();
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    dp_in = dp;
    e.bcd = ebcd;
    e.seg = eseg;
    e.ovf = eovf;
    e.cyc = cyc + 32'd16;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'h3FFF;
    chk("ready_low_after_accept", 64'(ready), 64'd0);
  endtask

  typedef struct packed {
    logic [13:0] b;
    logic [3:0]  dp;
    logic [15:0] bcd;
    logic [31:0] seg;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base;
    vecs[0] = '{14'd1234,  4'b0000, 16'h1234, 32'hF9A4B099, 1'b0};
    vecs[1] = '{14'd7,     4'b0000, 16'h0007, 32'hFFFFFFF8, 1'b0};
    vecs[2] = '{14'd0,     4'b0000, 16'h0000, 32'hFFFFFFC0, 1'b0};
    vecs[3] = '{14'd1005,  4'b0000, 16'h1005, 32'hF9C0C092, 1'b0};
    vecs[4] = '{14'd9999,  4'b0000, 16'h9999, 32'h90909090, 1'b0};
    vecs[5] = '{14'd10000, 4'b0000, 16'h0000, 32'hBFBFBFBF, 1'b1};
    vecs[6] = '{14'd1234,  4'b0100, 16'h1234, 32'hF924B099, 1'b0};
    vecs[7] = '{14'd16383, 4'b1111, 16'h0000, 32'h3F3F3F3F, 1'b1};
    vecs[8] = '{14'd50,    4'b1000, 16'h0050, 32'h7FFF92C0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    dp_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done_tick", 64'(done_tick), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_seg", 64'({seg3, seg2, seg1, seg0}), 64'hFFFFFFFF);
    chk("rst_bcd", 64'({bcd3, bcd2, bcd1, bcd0}), 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].b, vecs[i].dp, vecs[i].bcd, vecs[i].seg, vecs[i].ovf);
      wait_drain();
    end

    // Second start mid-conversion must be dropped.
    base = done_count;
    issue(14'd4321, 4'b0000, 16'h4321, 32'h99B0A4F9, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd8888;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    chk("single_done_for_ignored_start", 64'(done_count - base), 64'd1);

    // Reset mid-conversion aborts with no done_tick.
    base = done_count;
    wait_ready();
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    dp_in = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_done_tick", 64'(done_tick), 64'd0);
    chk("midrst_seg", 64'({seg3, seg2, seg1, seg0}), 64'hFFFFFFFF);
    chk("midrst_bcd", 64'({bcd3, bcd2, bcd1, bcd0}), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("no_done_after_reset", 64'(done_count - base), 64'd0);
    chk("ready_after_reset", 64'(ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
